scan_chain_ctrl: RTL and testbench
==================================

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 3, giving the number of flops in the controlled scan chain (legal range 1..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request one scan operation; sampled only in IDLE.
REQ-005 load_data  input  CHAIN_LEN  value to shift into the chain; captured on the accepted start edge.
REQ-006 chain_so  input  1  serial out of chain flop f[0].
REQ-007 scan_en  output  1  chain shift enable; when 1, chain does f[i]<=f[i+1], f[CHAIN_LEN-1]<=chain_si.
REQ-008 chain_si  output  1  serial data into chain flop f[CHAIN_LEN-1].
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 done  output  1  one-cycle pulse when unload_data is valid.
REQ-011 unload_data  output  CHAIN_LEN  chain contents captured during the shift.
REQ-012 unload_parity  output  1  XOR of unload_data; present only per REQ-031.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 -> SHIFT next cycle, shift register <= load_data, bit counter <= 0; start=0 -> stay IDLE.
REQ-015 SHIFT: SHALL last exactly CHAIN_LEN cycles; scan_en=1 in every SHIFT cycle and 0 in every other state.
REQ-016 In shift cycle k (k=0..CHAIN_LEN-1), chain_si SHALL equal load_data[k] and chain_so SHALL be captured into unload position k.
REQ-017 Implementation: right-shift register; chain_si = sreg[0]; each SHIFT edge sreg <= {chain_so, sreg[CHAIN_LEN-1:1]}.
REQ-018 After CHAIN_LEN shifts, chain f[k] SHALL hold load_data[k] and unload_data[k] SHALL equal the pre-scan f[k].
REQ-019 Counter width SHALL be clog2(CHAIN_LEN+1); SHIFT -> DONE when counter == CHAIN_LEN-1 at the edge; no wrap beyond.
REQ-020 DONE: exactly one cycle, done=1, busy=1, then IDLE unconditionally.
REQ-021 unload_data SHALL update only on entry to DONE and hold its value until the next DONE.
REQ-022 start asserted in SHIFT or DONE SHALL be ignored (not queued); start in the IDLE cycle following DONE SHALL be accepted (back-to-back ops: 1 idle cycle between).
REQ-023 Latency: start accepted at edge 0 -> done high in cycle CHAIN_LEN+1 -> busy low in cycle CHAIN_LEN+2.
REQ-024 load_data changes after the accepting edge SHALL NOT affect the operation.
REQ-025 chain_si SHALL be 0 when scan_en=0.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, counter=0, shift register=0, unload_data=0, unload_parity=0, overriding start.
REQ-027 After reset: scan_en=0, chain_si=0, busy=0, done=0.
REQ-028 rst during SHIFT SHALL abort immediately; chain left partially shifted; no done pulse generated.
REQ-029 start sampled only when rst=0.

Configuration
REQ-030 Macro SCAN_PARITY_EN SHALL select the parity feature.
REQ-031 Defined: unload_parity registered alongside unload_data as XOR of captured bits, valid from done, held to next DONE. Undefined: unload_parity tied 0, no parity logic; all else identical.

Verification (CHAIN_LEN=3, bench 3-flop chain model)
REQ-032 Chain preset 3'b101, start with load_data=3'b011 -> scan_en high 3 cycles, chain_si 1,1,0; done in cycle 4 with unload_data=3'b101; chain=3'b011.
REQ-033 Two back-to-back ops: load 3'b110 then 3'b001 (start held high) -> second unload_data=3'b110, chain=3'b001, one idle cycle between busy periods.
REQ-034 start pulses during SHIFT and DONE -> ignored; exactly one done pulse per accepted start.
REQ-035 rst asserted in shift cycle 1 -> next cycle busy=0, scan_en=0, unload_data=0, no done pulse.
REQ-036 SCAN_PARITY_EN defined, unload 3'b111 -> unload_parity=1; unload 3'b101 -> 0; undefined -> always 0.
REQ-037 CHAIN_LEN=1: start -> one shift cycle, done in cycle 2, unload_data = pre-scan f[0].

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: drives one complete scan operation on an external chain of
// CHAIN_LEN flops. It shifts load_data into the chain LSB-first and captures
// the previous chain contents into unload_data.
// Optional feature: define SCAN_PARITY_EN to register unload_parity as the XOR
// of the captured bits. When it is undefined, unload_parity is tied low.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] load_data,
    input  logic                 chain_so,
    output logic                 scan_en,
    output logic                 chain_si,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] unload_data,
    output logic                 unload_parity
);

    localparam int               CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CHAIN_LEN-1:0] sreg;
    logic [CHAIN_LEN-1:0] sreg_next;
    logic                 last_shift;

    // Right shift that brings the chain's serial output in at the MSB.
    // After CHAIN_LEN shifts, the bit captured first sits at position 0.
    function automatic logic [CHAIN_LEN-1:0] shift_in(
        input logic [CHAIN_LEN-1:0] cur,
        input logic                 so
    );
        logic [CHAIN_LEN-1:0] res;
        res = cur >> 1;
        res[CHAIN_LEN-1] = so;
        return res;
    endfunction

    assign sreg_next  = shift_in(sreg, chain_so);
    assign last_shift = (state_q == SHIFT) && (bit_cnt == CNT_LAST);

    // State register; reset overrides any pending start.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. Start is only looked at in IDLE, so a request made
    // during SHIFT or DONE is dropped rather than queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (bit_cnt == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state. chain_si is gated so that it stays low
    // whenever the chain is not shifting.
    always_comb begin
        scan_en  = 1'b0;
        chain_si = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            SHIFT: begin
                scan_en  = 1'b1;
                chain_si = sreg[0];
                busy     = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift register and bit counter. load_data is copied on the accepting
    // edge, so later changes to it cannot disturb the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sreg    <= load_data;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    sreg <= sreg_next;
                    if (bit_cnt != CNT_LAST) bit_cnt <= bit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Captured chain contents are published only on entry to DONE and are
    // held until the next DONE.
    always_ff @(posedge clk) begin
        if (rst)             unload_data <= '0;
        else if (last_shift) unload_data <= sreg_next;
    end

`ifdef SCAN_PARITY_EN
    // Parity is registered on the same edge as unload_data.
    always_ff @(posedge clk) begin
        if (rst)             unload_parity <= 1'b0;
        else if (last_shift) unload_parity <= ^sreg_next;
    end
`else
    assign unload_parity = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl. A 3-flop chain model is attached to the
// default instance and a 1-flop chain model to a CHAIN_LEN=1 instance.
// Inputs are driven and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_scan_chain_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] load_data;
    logic       scan_en, chain_si, busy, done, unload_parity;
    logic [2:0] unload_data;

    logic       start1;
    logic [0:0] load1;
    logic       scan_en1, chain_si1, busy1, done1, unload_parity1;
    logic [0:0] unload1;

    logic [2:0] chain;
    logic [0:0] chain1;
    logic       preset_en;
    logic [2:0] preset_val;
    logic [0:0] preset_val1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.CHAIN_LEN(3)) dut (
        .clk(clk), .rst(rst), .start(start), .load_data(load_data),
        .chain_so(chain[0]), .scan_en(scan_en), .chain_si(chain_si),
        .busy(busy), .done(done), .unload_data(unload_data),
        .unload_parity(unload_parity)
    );

    scan_chain_ctrl #(.CHAIN_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .load_data(load1),
        .chain_so(chain1[0]), .scan_en(scan_en1), .chain_si(chain_si1),
        .busy(busy1), .done(done1), .unload_data(unload1),
        .unload_parity(unload_parity1)
    );

    // Chain models: f[i] <= f[i+1], f[top] <= chain_si while scan_en is high.
    always @(posedge clk) begin
        if (preset_en) begin
            chain  <= preset_val;
            chain1 <= preset_val1;
        end else begin
            if (scan_en)  chain  <= {chain_si, chain[2:1]};
            if (scan_en1) chain1 <= chain_si1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preset(input logic [2:0] v, input logic v1);
        preset_val  = v;
        preset_val1 = v1;
        preset_en   = 1'b1;
        step();
        preset_en   = 1'b0;
    endtask

    // One operation on the 3-flop chain with fixed-latency checks on every cycle.
    task automatic do_op(input string tag, input logic [2:0] ld,
                         input logic [2:0] exp_unload, input logic [2:0] exp_chain);
        logic exp_par;
`ifdef SCAN_PARITY_EN
        exp_par = ^exp_unload;
`else
        exp_par = 1'b0;
`endif
        start = 1'b1;
        load_data = ld;
        step();
        start = 1'b0;
        load_data = ~ld;
        for (int k = 0; k < 3; k++) begin
            check({tag, "_scan_en"}, scan_en, 1'b1);
            check({tag, "_chain_si"}, chain_si, ld[k]);
            check({tag, "_done_early"}, done, 1'b0);
            step();
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_done"}, busy, 1'b1);
        check({tag, "_scan_en_off"}, scan_en, 1'b0);
        check({tag, "_chain_si_off"}, chain_si, 1'b0);
        check({tag, "_unload"}, unload_data, exp_unload);
        check({tag, "_parity"}, unload_parity, exp_par);
        check({tag, "_chain"}, chain, exp_chain);
        step();
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_done_low"}, done, 1'b0);
        check({tag, "_unload_hold"}, unload_data, exp_unload);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        start1 = 1'b0;
        load_data = 3'b111;
        load1 = 1'b0;
        preset_en = 1'b0;
        preset_val = 3'b000;
        preset_val1 = 1'b0;
        step();
        step();
        // Reset takes priority over start.
        check("rst_busy", busy, 1'b0);
        check("rst_scan_en", scan_en, 1'b0);
        check("rst_chain_si", chain_si, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_unload", unload_data, 3'b000);
        check("rst_parity", unload_parity, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        rst = 1'b0;
        start = 1'b0;
        step();
        check("idle_busy", busy, 1'b0);

        // Basic operation: chain 101, load 011.
        preset(3'b101, 1'b1);
        do_op("op1", 3'b011, 3'b101, 3'b011);

        // Back-to-back operations with start held high; load changes after accept.
        start = 1'b1;
        load_data = 3'b110;
        step();
        load_data = 3'b001;
        for (int n = 1; n <= 10; n++) begin
            if (n == 4) begin
                check("b2b_done1", done, 1'b1);
                check("b2b_unload1", unload_data, 3'b011);
                check("b2b_chain1", chain, 3'b110);
            end
            if (n == 5) check("b2b_idle_gap", busy, 1'b0);
            if (n == 6) check("b2b_busy2", busy, 1'b1);
            if (n == 9) begin
                check("b2b_done2", done, 1'b1);
                check("b2b_unload2", unload_data, 3'b110);
                check("b2b_chain2", chain, 3'b001);
                start = 1'b0;
            end
            if (n == 10) check("b2b_end_busy", busy, 1'b0);
            step();
        end

        // Start pulses during SHIFT and DONE are ignored.
        done_seen = 0;
        start = 1'b1;
        load_data = 3'b010;
        step();
        start = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (done) done_seen++;
            if (n == 2) start = 1'b1;
            if (n == 4) check("ign_unload", unload_data, 3'b001);
            if (n == 5) start = 1'b0;
            if (n == 5 || n == 6) check("ign_not_queued", busy, 1'b0);
            step();
        end
        check("ign_done_count", done_seen, 1);
        check("ign_chain", chain, 3'b010);

        // Reset during shift cycle 1 aborts without a done pulse.
        start = 1'b1;
        load_data = 3'b111;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("abort_busy", busy, 1'b0);
        check("abort_scan_en", scan_en, 1'b0);
        check("abort_unload", unload_data, 3'b000);
        check("abort_done", done, 1'b0);
        check("abort_chain", chain, 3'b110);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 5; n++) begin
            if (done || busy) done_seen++;
            step();
        end
        check("abort_no_done", done_seen, 0);

        // Parity cases: unload 110, then 111, then 101.
        do_op("par0", 3'b111, 3'b110, 3'b111);
        do_op("par111", 3'b101, 3'b111, 3'b101);
        do_op("par101", 3'b000, 3'b101, 3'b000);

        // CHAIN_LEN=1 instance: one shift cycle, done in cycle 2.
        preset(3'b000, 1'b1);
        start1 = 1'b1;
        load1 = 1'b0;
        step();
        start1 = 1'b0;
        check("len1_scan_en", scan_en1, 1'b1);
        check("len1_chain_si", chain_si1, 1'b0);
        check("len1_done_early", done1, 1'b0);
        step();
        check("len1_done", done1, 1'b1);
        check("len1_unload", unload1, 1'b1);
        check("len1_chain", chain1, 1'b0);
        check("len1_scan_en_off", scan_en1, 1'b0);
        step();
        check("len1_busy_low", busy1, 1'b0);
        check("len1_parity", unload_parity1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
